rr_encoder: RTL
===============

RR_ENCODER -- requirements
Module: rr_encoder

Interface
REQ-001 Parameter NUMW, default 4: width of the granted channel number.
REQ-002 Parameter BITW, default 2**NUMW: number of request channels.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  BITW  per-channel request bitmap; bit i high = channel i requests service.
REQ-006 ack  input  1  consumer done with current grant; meaningful only while ena=1.
REQ-007 ena  output  1  registered; high = number holds a valid grant; drives a decoder enable directly.
REQ-008 number  output  NUMW  registered; index of the granted channel.

Function
REQ-009 The block SHALL be a registered round-robin arbiter-encoder with a two-state FSM: IDLE (ena=0) and GRANT (ena=1).
REQ-010 An internal pointer ptr[NUMW-1:0] SHALL mark the highest-priority channel; the search order SHALL be ptr, ptr+1, ..., BITW-1, 0, ..., ptr-1 (modulo BITW).
REQ-011 In IDLE, if req is nonzero at a clock edge, the block SHALL load number with the first set bit in search order, set ena=1 and enter GRANT on that edge (1-cycle latency: req sampled cycle N, ena high cycle N+1).
REQ-012 In IDLE with req=0, ena SHALL stay 0 and number SHALL hold its last value.
REQ-013 In GRANT without ack, number and ena SHALL hold unchanged, regardless of req changes, including deassertion of the granted channel's req bit.
REQ-014 In GRANT with ack=1, ptr SHALL become number+1 modulo BITW (BITW-1 wraps to 0).
REQ-015 Arbitration on that same ack edge SHALL use the new pointer value.
REQ-016 In GRANT with ack=1, if req is nonzero, the block SHALL grant the next channel in search order on that same edge (back-to-back, ena stays 1, no bubble).
REQ-017 In GRANT with ack=1, if req is zero, the block SHALL clear ena and return to IDLE.
REQ-018 The previously granted channel SHALL be eligible in a back-to-back grant only if it is the sole requester, in which case it is re-granted.
REQ-019 ack while in IDLE SHALL be ignored: no state, pointer or output change.
REQ-020 ptr SHALL update only on an accepted ack, never on a new grant from IDLE.
REQ-021 Unsupported request bits: none; all BITW bits SHALL be arbitrated.
REQ-022 number SHALL always be a value in 0..BITW-1.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set ena=0, number=0, ptr=0 and state=IDLE, overriding req and ack.
REQ-024 Reset asserted during GRANT SHALL drop ena on the next edge, with no ack required.
REQ-025 After reset deasserts, arbitration SHALL restart from channel 0.
REQ-026 No output SHALL change asynchronously to clk.

Verification (NUMW=4)
REQ-027 Idle check: rst pulse, req=0x0000 for 10 cycles -> ena=0, number=0 throughout; ack=1 pulses cause no change.
REQ-028 Basic grant and back-to-back:
- req=0x0028 held from IDLE after reset -> next cycle ena=1, number=3; held for 3 cycles without ack, number stays 3.
- ack=1 for one cycle -> next cycle ena=1, number=5.
- ack again with req=0x0028 -> number=3 (pointer wrapped 6..15,0..3).
REQ-029 Wrap: reach grant number=15, then set req=0x8001 and pulse ack -> next cycle number=0, ena=1.
REQ-030 Sole requester: req=0x0004, grant number=2, keep req=0x0004 and pulse ack -> number=2 again, ena=1; drop req to 0 and pulse ack -> ena=0 next cycle.
REQ-031 Withdraw and reset mid-grant:
- Granted number=7 with req=0x0080; set req=0x0000 without ack -> ena=1, number=7 held.
- Assert rst for one cycle -> ena=0, number=0 next edge.
- Then req=0x0080 -> number=7 granted 1 cycle after rst deasserts, pointer restarted at 0.

Source files
------------

// File: rtl/rr_encoder.sv
// Registered round-robin arbiter-encoder: grants one requesting channel at a time
// and rotates priority to the channel after the last granted one on each ack.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no valid grant, ena=0, number holds last value
//   GRANT | number holds a valid grant, ena=1, waiting for ack
module rr_encoder #(
    parameter int NUMW = 4,
    parameter int BITW = 2 ** NUMW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITW-1:0] req,
    input  logic            ack,
    output logic            ena,
    output logic [NUMW-1:0] number
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NUMW-1:0]   ptr_q, ptr_d;
    logic [NUMW-1:0]   number_q, number_d;
    logic              ena_q, ena_d;

    logic [NUMW-1:0]   ptr_inc;
    logic [NUMW-1:0]   search_base;
    logic [2*BITW-1:0] req_dbl;
    logic [BITW-1:0]   req_rot;
    logic [NUMW-1:0]   rot_off;
    logic [NUMW:0]     pick_sum;
    logic [NUMW-1:0]   pick;
    logic              req_any;

    assign req_any = |req;
    assign ptr_inc = (number_q == NUMW'(BITW - 1)) ? '0 : number_q + 1'b1;

    // On an accepted ack the search starts from the freshly advanced pointer.
    assign search_base = (state_q == GRANT) ? ptr_inc : ptr_q;

    // Rotate so search_base lands at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req} >> search_base;
        req_rot = req_dbl[BITW-1:0];
        rot_off = '0;
        for (int i = BITW - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = NUMW'(i);
            end
        end
        pick_sum = {1'b0, search_base} + {1'b0, rot_off};
        if (pick_sum >= (NUMW + 1)'(BITW)) begin
            pick_sum = pick_sum - (NUMW + 1)'(BITW);
        end
        pick = pick_sum[NUMW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        number_d = number_q;
        ena_d    = ena_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    number_d = pick;
                    ena_d    = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_d = ptr_inc;
                    if (req_any) begin
                        number_d = pick;
                    end else begin
                        ena_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ena_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            number_q <= '0;
            ena_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            number_q <= number_d;
            ena_q    <= ena_d;
        end
    end

    assign ena    = ena_q;
    assign number = number_q;

endmodule
